shared_mem_arbiter: RTL and testbench



---
 rtl/shared_mem_arbiter_pkg.sv | 23 ++
 rtl/shared_mem_arbiter_rr_picker.sv | 34 +++
 rtl/shared_mem_arbiter.sv | 111 +++++++++++
 tb/tb_shared_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types and constants for the shared-memory arbiter: operation codes,
// FSM encoding and default data/address widths.
package shared_mem_arbiter_pkg;

  localparam logic [1:0] MEM_OP_NONE = 2'b00;
  localparam logic [1:0] MEM_OP_RD   = 2'b01;
  localparam logic [1:0] MEM_OP_WR   = 2'b10;

  localparam int DEF_REG_SIZE  = 8;
  localparam int DEF_ADDR_SIZE = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  // The reserved code 2'b11 is deliberately not a request.
  function automatic logic is_req(input logic [1:0] op);
    return (op == MEM_OP_RD) || (op == MEM_OP_WR);
  endfunction

endpackage

// File: rtl/shared_mem_arbiter_rr_picker.sv
// Combinational picker: first requester at or after ptr, searching upward with
// wrap. Driving ptr with zero gives the fixed lowest-index-wins variant.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  int            j;
  logic [IW-1:0] jj;

  // Walk the search order backwards so the last hit is the first in order.
  always_comb begin
    grant = '0;
    index = '0;
    j     = 0;
    jj    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (req[jj]) begin
        grant     = '0;
        grant[jj] = 1'b1;
        index     = jj;
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbitrates CORE_COUNT cores onto one single-port memory, IDLE->ACCESS->RESP.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no RR pointer).
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int CORE_COUNT = 4,
  parameter int REG_SIZE   = DEF_REG_SIZE,
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2*CORE_COUNT-1:0]         enable,
  input  logic [ADDR_SIZE*CORE_COUNT-1:0] addr,
  input  logic [REG_SIZE*CORE_COUNT-1:0]  wr_data,
  output logic [REG_SIZE-1:0]             rd_data,
  output logic [CORE_COUNT-1:0]           ready_sig,
  output logic [1:0]                      dbg_state
);

  localparam int IW = $clog2(CORE_COUNT);
  localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  arb_state_t            state;
  logic [CORE_COUNT-1:0] req, grant, win_grant;
  logic [IW-1:0]         pick_idx, ptr_in, win_idx;
  logic [1:0]            sel_op, win_op;
  logic [ADDR_SIZE-1:0]  sel_addr, win_addr;
  logic [REG_SIZE-1:0]   sel_data, win_data;
  logic [REG_SIZE-1:0]   mem [MEM_DEPTH];
  logic                  in_range;

  assign dbg_state = state;
  assign in_range  = (32'(win_addr) < MEM_DEPTH);

  always_comb begin
    req      = '0;
    sel_op   = MEM_OP_NONE;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      req[i] = is_req(enable[2*i +: 2]);
      if (grant[i]) begin
        sel_op   = enable[2*i +: 2];
        sel_addr = addr[i*ADDR_SIZE +: ADDR_SIZE];
        sel_data = wr_data[i*REG_SIZE +: REG_SIZE];
      end
    end
  end

  rr_picker #(.N(CORE_COUNT), .IW(IW)) u_picker (
    .req   (req),
    .ptr   (ptr_in),
    .grant (grant),
    .index (pick_idx)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr_in = '0;
`else
  logic [IW-1:0] rr_ptr;
  assign ptr_in = rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else if (state == ARB_RESP)
      rr_ptr <= (win_idx == IW'(CORE_COUNT - 1)) ? '0 : win_idx + IW'(1);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      ready_sig <= '0;
      rd_data   <= '0;
      win_grant <= '0;
      win_idx   <= '0;
      win_op    <= MEM_OP_NONE;
      win_addr  <= '0;
      win_data  <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (|req) begin
          win_grant <= grant;
          win_idx   <= pick_idx;
          win_op    <= sel_op;
          win_addr  <= sel_addr;
          win_data  <= sel_data;
          state     <= ARB_ACCESS;
        end
        ARB_ACCESS: begin
          if (win_op == MEM_OP_RD) rd_data <= in_range ? mem[win_addr[MW-1:0]] : '0;
          ready_sig <= win_grant;
          state     <= ARB_RESP;
        end
        ARB_RESP: begin
          ready_sig <= '0;
          state     <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Contents survive reset; reset forces IDLE, so an unfinished write never lands.
  always_ff @(posedge clk) begin
    if (state == ARB_ACCESS && win_op == MEM_OP_WR && in_range)
      mem[win_addr[MW-1:0]] <= win_data;
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: cycle-level service model plus
// hand-computed grant/readback logs per scenario.
module tb_shared_mem_arbiter;
  import shared_mem_arbiter_pkg::*;

  localparam int N = 4, RS = 8, AS = 8, DEPTH = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2*N-1:0]  enable;
  logic [AS*N-1:0] addr;
  logic [RS*N-1:0] wr_data;
  logic [RS-1:0]   rd_data;
  logic [N-1:0]    ready_sig;
  logic [1:0]      dbg_state;

  shared_mem_arbiter #(.CORE_COUNT(N), .REG_SIZE(RS), .ADDR_SIZE(AS), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .ready_sig(ready_sig), .dbg_state(dbg_state)
  );

  int n_checks = 0, n_errors = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One access per 3 cycles: a request seen at free edge k completes with a
  // ready pulse visible after edge k+1; the next decision is at edge k+3.
  logic [7:0] model_mem [256];
  int         m_ptr, m_win, m_ready_at, m_free_at, m_rd_at, m_w, m_j, m_a, m_start;
  logic [7:0] m_rd, m_rd_pend;
  logic [1:0] m_op;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      m_ptr = 0; m_ready_at = -1; m_free_at = 0; m_rd = 8'h00; m_rd_at = -1;
    end else begin
      if (cyc == m_rd_at) m_rd = m_rd_pend;
      if (cyc >= m_free_at) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        m_start = 0;
`else
        m_start = m_ptr;
`endif
        m_w = -1;
        for (int k = 0; k < N; k++) begin
          m_j = (m_start + k) % N;
          if (m_w < 0 && (enable[2*m_j +: 2] == 2'b01 || enable[2*m_j +: 2] == 2'b10)) m_w = m_j;
        end
        if (m_w >= 0) begin
          m_op       = enable[2*m_w +: 2];
          m_a        = int'(addr[m_w*AS +: AS]);
          m_win      = m_w;
          m_ready_at = cyc + 1;
          m_free_at  = cyc + 3;
          m_ptr      = (m_w + 1) % N;
          if (m_op == 2'b10 && m_a < DEPTH) model_mem[m_a] = wr_data[m_w*RS +: RS];
          if (m_op == 2'b01) begin
            m_rd_pend = (m_a < DEPTH) ? model_mem[m_a] : 8'h00;
            m_rd_at   = cyc + 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [1:0] served_q [$];
  logic [7:0] rdlog_q [$];
  int         rdycyc_q [$];
  logic [1:0] exp_srv_q [$];
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (reset) begin
      check("ready_sig", 32'(ready_sig), (cyc == m_ready_at) ? (32'd1 << m_win) : 32'd0);
      check("rd_data", 32'(rd_data), 32'(m_rd));
      for (int i = 0; i < N; i++) begin
        if (ready_sig[i]) begin
          served_q.push_back(2'(i));
          rdlog_q.push_back(rd_data);
          rdycyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic clear_logs();
    served_q.delete(); rdlog_q.delete(); rdycyc_q.delete();
    exp_srv_q.delete(); exp_q.delete();
  endtask

  task automatic check_logs(input string name, input int spacing);
    check({name, "_count"}, served_q.size(), exp_srv_q.size());
    for (int i = 0; i < exp_srv_q.size(); i++) begin
      if (i < served_q.size()) begin
        check({name, "_core"}, 32'(served_q[i]), 32'(exp_srv_q[i]));
        check({name, "_rd"}, 32'(rdlog_q[i]), 32'(exp_q[i]));
        if (spacing > 0 && i > 0) check({name, "_gap"}, rdycyc_q[i] - rdycyc_q[i-1], spacing);
      end
    end
  endtask

  // ---------------- core drivers ----------------
  typedef struct packed { logic [1:0] op; logic [7:0] a; logic [7:0] d; } req_t;
  req_t       core_q [N][$];
  req_t       drv_r;
  logic [N-1:0] active = '0;
  logic [N-1:0] kill = '0;

  task automatic push(input int c, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    core_q[c].push_back({op, a, d});
  endtask

  function automatic logic queues_busy();
    for (int i = 0; i < N; i++) if (core_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Each core holds its request until it sees its ready pulse, then loads the next.
  initial begin
    enable = '0; addr = '0; wr_data = '0;
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (kill[i]) begin
          core_q[i].delete(); active[i] = 1'b0; enable[2*i +: 2] = 2'b00; kill[i] = 1'b0;
        end else if (active[i] && ready_sig[i]) begin
          active[i] = 1'b0; enable[2*i +: 2] = 2'b00;
        end
        if (!active[i] && core_q[i].size() != 0) begin
          drv_r = core_q[i].pop_front();
          enable[2*i +: 2]     = drv_r.op;
          addr[i*AS +: AS]     = drv_r.a;
          wr_data[i*RS +: RS]  = drv_r.d;
          active[i]            = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((active != '0 || queues_busy()) && t < 300) begin @(negedge clk); t++; end
    check({name, "_done"}, 32'(t < 300), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", 32'(ready_sig), 32'd0);
    check("reset_rd", 32'(rd_data), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ARB_IDLE));
    @(negedge clk); #2 reset = 1'b1;

    // Write then read back on core 0.
    clear_logs();
    push(0, 2'b10, 8'h10, 8'hA5); push(0, 2'b01, 8'h10, 8'h00);
    wait_idle("t1");
    exp_srv_q = '{2'd0, 2'd0}; exp_q = '{8'h00, 8'hA5};
    check_logs("t1", 3);

    // Preload, reset, then all four cores read together.
    push(0, 2'b10, 8'h20, 8'h11); push(0, 2'b10, 8'h21, 8'h22);
    push(0, 2'b10, 8'h22, 8'h33); push(0, 2'b10, 8'h23, 8'h44);
    wait_idle("t2_pre");
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) push(i, 2'b01, 8'(8'h20 + i), 8'h00);
    wait_idle("t2");
    exp_srv_q = '{2'd0, 2'd1, 2'd2, 2'd3}; exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_logs("t2", 3);

    // Cores 1 and 3 contend continuously.
    clear_logs();
    for (int i = 0; i < 3; i++) begin push(1, 2'b01, 8'h10, 8'h00); push(3, 2'b01, 8'h21, 8'h00); end
    wait_idle("t3");
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_srv_q = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
    exp_q = '{8'hA5, 8'hA5, 8'hA5, 8'h22, 8'h22, 8'h22};
`else
    exp_srv_q = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
    exp_q = '{8'hA5, 8'h22, 8'hA5, 8'h22, 8'hA5, 8'h22};
`endif
    check_logs("t3", 3);

    // Address bounds with a 128-word memory.
    clear_logs();
    push(2, 2'b10, 8'hFF, 8'h5A); push(2, 2'b01, 8'hFF, 8'h00);
    push(2, 2'b10, 8'h7F, 8'h77); push(2, 2'b01, 8'h7F, 8'h00);
    push(2, 2'b01, 8'h80, 8'h00);
    wait_idle("t4");
    exp_srv_q = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2}; exp_q = '{8'h22, 8'h00, 8'h00, 8'h77, 8'h00};
    check_logs("t4", 0);

    // Asynchronous reset during the ACCESS cycle of a read.
    push(1, 2'b10, 8'h30, 8'hC3); push(1, 2'b01, 8'h30, 8'h00);
    wait_idle("t5_pre");
    check("t5_pre_rd", 32'(rd_data), 32'hC3);
    clear_logs();
    push(3, 2'b01, 8'h7F, 8'h00);
    t = 0;
    while (dbg_state != 2'(ARB_ACCESS) && t < 20) begin @(posedge clk); #1; t++; end
    check("t5_access_seen", 32'(t < 20), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t5_ready", 32'(ready_sig), 32'd0);
    check("t5_rd", 32'(rd_data), 32'd0);
    check("t5_state", 32'(dbg_state), 32'(ARB_IDLE));
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    wait_idle("t5");
    exp_srv_q = '{2'd3}; exp_q = '{8'h77};
    check_logs("t5", 0);

    // Reserved code is never granted.
    clear_logs();
    push(2, 2'b11, 8'h40, 8'h00);
    repeat (20) @(negedge clk);
    check("t6_served", served_q.size(), 32'd0);
    kill[2] = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
